// File: rtl/shift_reg_usr_pkg.sv
// shift_reg_usr_pkg: mode encoding shared by the universal shift register and its bench
package shift_reg_usr_pkg;
   typedef logic [1:0] mode_t;
   localparam mode_t MODE_HOLD = 2'b00;
   localparam mode_t MODE_SHR  = 2'b01;
   localparam mode_t MODE_SHL  = 2'b10;
   localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/usr_shift_cnt.sv
// usr_shift_cnt: modulo-WIDTH shift counter with clear; done pulses the cycle after a wrap
module usr_shift_cnt #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          done
);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d, wrap;
   assign wrap = cnt_q == CW'(WIDTH - 1);
   always_comb begin
      cnt_d  = clr ? '0 : !inc ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
      done_d = !clr && inc && wrap;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   assign cnt  = cnt_q;
   assign done = done_q;
endmodule

// File: rtl/shift_reg_usr.sv
// shift_reg_usr: universal shift register (hold/shr/shl/load) with shift counter and done pulse
// SHIFT_REG_USR_ROTATE_EN adds input rot: shifts recirculate the outgoing bit instead of sin.
module shift_reg_usr
   import shift_reg_usr_pkg::*;
#(
   parameter  int               WIDTH     = 8,
   parameter  logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int               CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  mode_t            mode,
   input  logic             sin,
`ifdef SHIFT_REG_USR_ROTATE_EN
   input  logic             rot,
`endif
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             done
);
   logic [WIDTH-1:0] q_q, q_d, shr, shl;
   logic             fill_r, fill_l;
`ifdef SHIFT_REG_USR_ROTATE_EN
   assign fill_r = rot ? q_q[0] : sin;
   assign fill_l = rot ? q_q[WIDTH-1] : sin;
`else
   assign fill_r = sin;
   assign fill_l = sin;
`endif
   // a 1-bit register has no bits to keep, so both shifts just take the fill bit
   if (WIDTH == 1) begin : g_one
      assign shr = fill_r;
      assign shl = fill_l;
   end else begin : g_multi
      assign shr = {fill_r, q_q[WIDTH-1:1]};
      assign shl = {q_q[WIDTH-2:0], fill_l};
   end
   always_comb
      q_d = !en ? q_q : mode == MODE_SHR ? shr : mode == MODE_SHL ? shl : mode == MODE_LOAD ? d : q_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) q_q <= RESET_VAL;
      else        q_q <= q_d;
   usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (en && mode == MODE_LOAD),
      .inc  (en && (mode == MODE_SHR || mode == MODE_SHL)),
      .cnt  (cnt),
      .done (done)
   );
   assign q      = q_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];
endmodule

// File: tb/tb_shift_reg_usr.sv
// tb_shift_reg_usr: directed self-checking bench for shift_reg_usr (WIDTH=8 and WIDTH=1)
module tb_shift_reg_usr;
   import shift_reg_usr_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   mode_t      mode = MODE_HOLD;
   logic       sin = 1'b0;
   logic       rot = 1'b0;
   logic [7:0] d = '0;
   logic [7:0] q;
   logic       sout_r, sout_l, done;
   logic [3:0] cnt;
   logic [0:0] q1;
   logic       sout_r1, sout_l1, done1;
   logic [0:0] cnt1;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   shift_reg_usr #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin),
`ifdef SHIFT_REG_USR_ROTATE_EN
      .rot(rot),
`endif
      .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
   );

   shift_reg_usr #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin),
`ifdef SHIFT_REG_USR_ROTATE_EN
      .rot(rot),
`endif
      .d(d[0:0]), .q(q1), .sout_r(sout_r1), .sout_l(sout_l1), .cnt(cnt1), .done(done1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] shr_q [8];
      logic [7:0] shr_so[8];
      shr_q  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
      shr_so = '{1, 0, 1, 0, 0, 1, 0, 1};
      #3 reset = 1'b0;
      #1;
      check("rst_q_now", q, 8'h00);
      check("rst_cnt_now", cnt, 0);
      check("rst_done_now", done, 0);
      step();
      step();
      check("rst_q", q, 8'h00);
      check("rst_sout_l", sout_l, 0);
      reset = 1'b1;
      en = 1'b1; mode = MODE_LOAD; d = 8'hA5;
      step();
      check("load_q", q, 8'hA5);
      check("load_cnt", cnt, 0);
      check("load_done", done, 0);
      check("load_sout_l", sout_l, 1);
      mode = MODE_SHR; sin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("shr_sout_r%0d", i), sout_r, shr_so[i]);
         step();
         check($sformatf("shr_q%0d", i), q, shr_q[i]);
         check($sformatf("shr_cnt%0d", i), cnt, (i + 1) % 8);
         check($sformatf("shr_done%0d", i), done, i == 7);
      end
      mode = MODE_SHL; sin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("shl_q%0d", i), q, (8'h01 << (i + 1)) - 8'h01);
         check($sformatf("shl_done%0d", i), done, i == 7);
      end
      check("shl_sout_l", sout_l, 1);
      sin = 1'b0;
      repeat (3) step();
      check("mid_q", q, 8'hF8);
      check("mid_cnt", cnt, 3);
      en = 1'b0; mode = MODE_SHR; sin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("en0_q%0d", i), q, 8'hF8);
         check($sformatf("en0_cnt%0d", i), cnt, 3);
         check($sformatf("en0_done%0d", i), done, 0);
      end
      en = 1'b1; mode = MODE_HOLD;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("hold_q%0d", i), q, 8'hF8);
         check($sformatf("hold_cnt%0d", i), cnt, 3);
         check($sformatf("hold_done%0d", i), done, 0);
      end
      mode = MODE_SHR; sin = 1'b0;
      step();
      step();
      check("pre_arst_q", q, 8'h3E);
      check("pre_arst_cnt", cnt, 5);
      #3 reset = 1'b0;
      #1;
      check("arst_q", q, 8'h00);
      check("arst_cnt", cnt, 0);
      check("arst_done", done, 0);
      step();
      reset = 1'b1; mode = MODE_HOLD;
      step();
      check("post_arst_done", done, 0);
      check("post_arst_cnt", cnt, 0);
      mode = MODE_SHR; sin = 1'b1;
      step();
      check("w1_shr_q", q1, 1);
      check("w1_shr_done", done1, 1);
      check("w1_shr_cnt", cnt1, 0);
      check("w1_sout", sout_r1 & sout_l1, 1);
      check("w8_after_w1_q", q, 8'h80);
      check("w8_after_w1_done", done, 0);
      mode = MODE_SHL; sin = 1'b0;
      step();
      check("w1_shl_q", q1, 0);
      check("w1_shl_done", done1, 1);
      mode = MODE_LOAD; d = 8'h01;
      step();
      check("w1_load_q", q1, 1);
      check("w1_load_done", done1, 0);
`ifdef SHIFT_REG_USR_ROTATE_EN
      d = 8'hA5;
      step();
      rot = 1'b1; mode = MODE_SHR; sin = 1'b0;
      step();
      check("rot_q1", q, 8'hD2);
      repeat (7) step();
      check("rot_q8", q, 8'hA5);
      check("rot_done", done, 1);
      rot = 1'b0;
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
